// File: rtl/loader_pkg.sv
// Shared types and stream-format constants for the instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int HDR_W      = 8 * HDR_BYTES;
  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into words; word_valid pulses the cycle after
// the last byte of a word is strobed in.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_stb,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_last
);

  logic [BCNT_W-1:0] byte_cnt;

  assign word_last = byte_stb && (byte_cnt == BCNT_W'(WORD_BYTES - 1));

  // Counter wraps naturally, so the next word starts at byte 0 without a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (byte_stb) begin
        word[{byte_cnt, 3'b000} +: 8] <= byte_data;
        byte_cnt                      <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into
// instruction memory while holding the core in reset.
//
// state  | meaning
// HDR_LO | waiting for word count low byte
// HDR_HI | waiting for word count high byte
// DATA   | streaming program words into memory
// DONE   | load complete, core released (terminal)
// ERR    | word count exceeds DEPTH, core held (terminal)
module inst_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  state_t           state, state_nxt;
  logic [HDR_W-1:0] n_words;
  logic [HDR_W-1:0] n_shift;
  logic [HDR_W-1:0] asm_cnt;
  logic             accept;
  logic             byte_stb;
  logic             word_last;

  assign accept   = rx_valid && rx_ready;
  assign byte_stb = accept && (state == DATA);
  // Header bytes arrive low first, so shift each one in from the top.
  assign n_shift  = {rx_data, n_words[HDR_W-1:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR_LO;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    core_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      HDR_LO: begin
        rx_ready = rst;
        if (accept) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        rx_ready = rst;
        if (accept) begin
          if (n_shift == '0)                state_nxt = DONE;
          else if (32'(n_shift) > DEPTH)    state_nxt = ERR;
          else                              state_nxt = DATA;
        end
      end
      DATA: begin
        rx_ready = rst;
        // Enter DONE alongside the final write strobe.
        if (word_last && (asm_cnt == n_words - HDR_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_nxt = HDR_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words <= '0;
      asm_cnt <= '0;
      wr_addr <= '0;
    end else begin
      if (accept && (state == HDR_LO || state == HDR_HI)) n_words <= n_shift;
      if (word_last) begin
        wr_addr <= ADDR_W'({asm_cnt, 2'b00});
        asm_cnt <= asm_cnt + 1'b1;
      end
    end
  end

  byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_stb   (byte_stb),
    .byte_data  (rx_data),
    .word       (wr_data),
    .word_valid (wr_en),
    .word_last  (word_last)
  );

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: drives byte streams and checks memory writes
// and status outputs against hand-computed values.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  int          cyc_q[$];
  logic        done_q[$];

  inst_loader #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_q.push_back(wr_addr);
      data_q.push_back(wr_data);
      cyc_q.push_back(cyc);
      done_q.push_back(done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    addr_q.delete();
    data_q.delete();
    cyc_q.delete();
    done_q.delete();
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_core_hold", 32'(core_hold), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_log();
    @(negedge clk);
    chk("post_rst_rx_ready", 32'(rx_ready), 1);
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the edge at which the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    rx_valid = 1'b0;
    if (gap > 0) begin
      rx_data = 8'($urandom);
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tries    = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      tries++;
      if (tries > 20) begin
        chk("rx_accept_timeout", 32'(rx_ready), 1);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic send_hdr(input logic [15:0] n, input int max_gap);
    send_byte(n[7:0], $urandom_range(0, max_gap));
    send_byte(n[15:8], $urandom_range(0, max_gap));
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2);
    logic [31:0] w[3];
    w = '{w0, w1, w2};
    chk({tag, "_count"}, 32'(data_q.size()), 32'(n));
    for (int i = 0; i < n && i < data_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), addr_q[i], 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), data_q[i], w[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single word load
    send_hdr(16'h0001, 0);
    send_word(32'h00500013, 0);
    repeat (3) @(negedge clk);
    check_writes("one", 1, 32'h00500013, 0, 0);
    if (done_q.size() > 0) chk("one_done_with_wr", 32'(done_q[0]), 1);
    chk("one_done", 32'(done), 1);
    chk("one_core_hold", 32'(core_hold), 0);
    chk("one_rx_ready", 32'(rx_ready), 0);
    chk("one_err", 32'(err), 0);

    // Empty program
    do_reset();
    send_hdr(16'h0000, 0);
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_core_hold", 32'(core_hold), 0);
    repeat (3) @(negedge clk);
    chk("zero_writes", 32'(data_q.size()), 0);

    // Oversize header, then stays in ERR despite further traffic
    do_reset();
    send_hdr(16'h0101, 0);
    @(negedge clk);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_rx_ready", 32'(rx_ready), 0);
    chk("ovf_core_hold", 32'(core_hold), 1);
    chk("ovf_done", 32'(done), 0);
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    chk("ovf_err_sticky", 32'(err), 1);
    chk("ovf_writes", 32'(data_q.size()), 0);

    // Exactly DEPTH words is legal
    do_reset();
    send_hdr(16'h0100, 0);
    @(negedge clk);
    chk("max_err", 32'(err), 0);
    chk("max_rx_ready", 32'(rx_ready), 1);

    // Three words, valid held continuously
    do_reset();
    send_hdr(16'h0003, 0);
    send_word(32'h11223344, 0);
    send_word(32'hA5A50F0F, 0);
    send_word(32'hDEADBEEF, 0);
    repeat (3) @(negedge clk);
    check_writes("b2b", 3, 32'h11223344, 32'hA5A50F0F, 32'hDEADBEEF);
    if (cyc_q.size() == 3) begin
      chk("b2b_space01", 32'(cyc_q[1] - cyc_q[0]), 4);
      chk("b2b_space12", 32'(cyc_q[2] - cyc_q[1]), 4);
      chk("b2b_done_w0", 32'(done_q[0]), 0);
      chk("b2b_done_w2", 32'(done_q[2]), 1);
    end
    chk("b2b_done", 32'(done), 1);

    // Two words with random gaps
    do_reset();
    send_hdr(16'h0002, 3);
    send_word(32'hCAFEF00D, 3);
    send_word(32'h01234567, 3);
    repeat (3) @(negedge clk);
    check_writes("gap", 2, 32'hCAFEF00D, 32'h01234567, 0);
    chk("gap_done", 32'(done), 1);

    // Reset right after the 6th byte aborts the pending write
    do_reset();
    send_hdr(16'h0002, 0);
    send_word(32'h89ABCDEF, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_rx_ready", 32'(rx_ready), 0);
    chk("abort_writes", 32'(data_q.size()), 0);
    do_reset();
    send_hdr(16'h0002, 0);
    send_word(32'h13579BDF, 1);
    send_word(32'h2468ACE0, 1);
    repeat (3) @(negedge clk);
    check_writes("reload", 2, 32'h13579BDF, 32'h2468ACE0, 0);
    chk("reload_done", 32'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the byte-address width of the write port.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: the incoming byte is valid.
REQ-006 SHALL have port rx_data, input, 8 bits: the incoming program byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port wr_en, output, 1 bit: instruction memory write strobe.
REQ-009 SHALL have port wr_addr, output, ADDR_W bits: word-aligned byte address for the write.
REQ-010 SHALL have port wr_data, output, 32 bits: instruction word to write.
REQ-011 SHALL have port core_hold, output, 1 bit: when 1, the processor is held in reset.
REQ-012 SHALL have port done, output, 1 bit: load completed successfully.
REQ-013 SHALL have port err, output, 1 bit: the header word count exceeds DEPTH.

Function
REQ-014 SHALL treat a byte as accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-015 SHALL use the stream format: 16-bit word count N (low byte first), then N words of 4 bytes each, little-endian.
REQ-016 SHALL implement states HDR_LO, HDR_HI, DATA, DONE and ERR.
REQ-017 SHALL drive rx_ready=1 in HDR_LO, HDR_HI and DATA, and rx_ready=0 in DONE and ERR.
REQ-018 SHALL move HDR_LO->HDR_HI on an accepted byte, storing it as N[7:0].
REQ-019 SHALL, on an accepted byte in HDR_HI, store it as N[15:8] and go to DONE if N==0, to ERR if N>DEPTH, otherwise to DATA.
REQ-020 SHALL, in DATA, place accepted bytes 0..3 of each word into wr_data bits [7:0], [15:8], [23:16] and [31:24] respectively.
REQ-021 SHALL use a 2-bit byte counter that wraps 3->0 on each completed word.
REQ-022 SHALL pulse wr_en high for exactly one cycle, in the cycle after the 4th byte of a word is accepted, with wr_data and wr_addr valid in that same cycle.
REQ-023 SHALL set wr_addr = 4*k for the k-th word (k from 0); the word index counts 0..N-1 and does not wrap.
REQ-024 SHALL enter DONE in the same cycle as the wr_en pulse of word N-1.
REQ-025 SHALL not stall the stream: a byte accepted during a wr_en cycle is the next word's byte 0 and is not lost.
REQ-026 SHALL ignore rx_data whenever rx_valid is 0; a gap between bytes leaves all state unchanged.
REQ-027 SHALL drive core_hold=1 in every state except DONE, and core_hold=0 in DONE.
REQ-028 SHALL drive done=1 only in DONE and err=1 only in ERR.
REQ-029 SHALL make DONE and ERR terminal; only reset leaves them.

Reset
REQ-030 SHALL, while rst is 0, force state=HDR_LO, N=0, counters=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, core_hold=1 and rx_ready=0.
REQ-031 SHALL abort any partial load on reset assertion mid-stream, with no wr_en pulse during or after reset.
REQ-032 SHALL drive rx_ready=1 in the first cycle after reset is released.

Structure
REQ-033 SHALL take the state enum, the header byte count (2) and the word byte count (4) from a shared package, loader_pkg.
REQ-034 SHALL factor byte-to-word assembly into one sub-module, byte_packer, which takes byte and strobe inputs and produces word and word_valid outputs.

Verification
REQ-035 SHALL cover header 0x0001 followed by bytes 13 00 50 00 -> exactly one wr_en pulse with addr 0x0 and data 0x00500013, then done=1 and core_hold=0.
REQ-036 SHALL cover header 0x0000 -> DONE one cycle after the 2nd byte, with no wr_en pulse.
REQ-037 SHALL cover header 0x0101 with DEPTH=256 -> err=1, rx_ready=0, core_hold=1 and no writes.
REQ-038 SHALL cover N=3 with rx_valid held high continuously -> wr_en pulses at addr 0x0, 0x4 and 0x8, spaced 4 cycles apart.
REQ-039 SHALL cover N=2 with random rx_valid gaps -> the same addresses and data as a gap-free run of the same stream.
REQ-040 SHALL cover reset asserted after the 6th byte of N=2 -> no writes; the subsequent full stream then loads correctly from addr 0x0.
